// File: rtl/param_def.sv
// param_def: shared Viterbi decoder constants and the branch-metric sequencer state type
package param_def;
    localparam int SLICED_INPUT_NUM = 6;
    localparam int MAX_STATE_NUM    = 256;
    localparam int RADIX            = 4;
    localparam int MAX_INPUT_NUM    = 4;
    localparam int SWEEP_CNT        = RADIX * MAX_STATE_NUM;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        RUN,
        WAIT_TB
    } bm_seq_state_t;
endpackage

// File: rtl/bm_sweep_cnt.sv
// bm_sweep_cnt: W-bit sweep counter with clear, enable and terminal count at LEN-1
module bm_sweep_cnt #(
    parameter int W   = 10,
    parameter int LEN = 1 << W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);
    assign tc = cnt == W'(LEN - 1);

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);
endmodule

// File: rtl/bm_sequencer.sv
// bm_sequencer: branch-metric table sweep then framed symbol admission; BM_SEQ_RECAL_EN adds i_recal re-sweep
module bm_sequencer
    import param_def::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int SWEEP_LEN = SWEEP_CNT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [5:0]  i_code,
    input  logic        i_cal_done,
    input  logic [5:0]  i_sym,
    input  logic        i_sym_valid,
    output logic        o_sym_ready,
    input  logic        i_tb_done,
`ifdef BM_SEQ_RECAL_EN
    input  logic        i_recal,
`endif
    output logic        o_en_bm,
    output logic [15:0] o_mux,
    output logic [9:0]  o_sweep_addr,
    output logic [5:0]  o_rx,
    output logic        o_rx_valid,
    output logic        o_frame_end,
    output logic        o_table_ready,
    output logic        o_err
);
    bm_seq_state_t state, state_nxt;
    logic [9:0]  cnt;
    logic [15:0] sym_cnt;
    logic        tc, hs, last, recal;

`ifdef BM_SEQ_RECAL_EN
    assign recal = i_recal && (state == WAIT_TB || (state == RUN && sym_cnt == '0));
`else
    assign recal = 1'b0;
`endif

    assign hs           = i_sym_valid && o_sym_ready;
    assign last         = hs && sym_cnt == 16'(FRAME_LEN - 1);
    assign o_en_bm      = state != IDLE;
    assign o_sym_ready  = state == RUN;
    assign o_sweep_addr = state == SWEEP ? cnt : '0;
    assign o_mux        = state == SWEEP ? {cnt, i_code} : o_en_bm ? 16'hFFFF : 16'h0000;

    bm_sweep_cnt #(.W(10), .LEN(SWEEP_LEN)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state != SWEEP || tc),
        .en  (state == SWEEP),
        .cnt (cnt),
        .tc  (tc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = i_start ? SWEEP : IDLE;
            SWEEP:   state_nxt = tc ? RUN : SWEEP;
            RUN:     state_nxt = recal ? SWEEP : last ? WAIT_TB : RUN;
            WAIT_TB: state_nxt = recal ? SWEEP : i_tb_done ? RUN : WAIT_TB;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state         <= IDLE;
            sym_cnt       <= '0;
            o_rx          <= '0;
            o_rx_valid    <= 1'b0;
            o_frame_end   <= 1'b0;
            o_table_ready <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            sym_cnt     <= (recal || last) ? '0 : hs ? sym_cnt + 16'd1 : sym_cnt;
            o_rx        <= hs ? i_sym : o_rx;
            o_rx_valid  <= hs;
            o_frame_end <= last;
            if (state == SWEEP && tc)
                o_table_ready <= 1'b1;
            else if (recal)
                o_table_ready <= 1'b0;
            if (state == SWEEP && i_cal_done != tc)
                o_err <= 1'b1;
        end
endmodule

// File: tb/tb_bm_sequencer.sv
// tb_bm_sequencer: directed and randomized checks of bm_sequencer against a sweep/frame reference model
module tb_bm_sequencer;
    localparam int FL = 4;
    localparam int SL = 1024;

    logic        clk = 0, rst = 0, i_start = 0, i_cal_done = 0, i_sym_valid = 0, i_tb_done = 0;
    logic [5:0]  i_code, i_sym = '0;
    logic        o_sym_ready, o_en_bm, o_rx_valid, o_frame_end, o_table_ready, o_err;
    logic [15:0] o_mux;
    logic [9:0]  o_sweep_addr;
    logic [5:0]  o_rx;
`ifdef BM_SEQ_RECAL_EN
    logic        i_recal = 0;
`endif

    int errors = 0, checks = 0, m_acc = 0;
    logic m_valid = 0, m_end = 0, m_ready = 0, m_tr = 0, m_err = 0;
    logic [5:0] m_rx = '0;

    always #5 clk = ~clk;

    assign i_code = o_sweep_addr[5:0] ^ 6'h2A;

    bm_sequencer #(.FRAME_LEN(FL)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_code        (i_code),
        .i_cal_done    (i_cal_done),
        .i_sym         (i_sym),
        .i_sym_valid   (i_sym_valid),
        .o_sym_ready   (o_sym_ready),
        .i_tb_done     (i_tb_done),
`ifdef BM_SEQ_RECAL_EN
        .i_recal       (i_recal),
`endif
        .o_en_bm       (o_en_bm),
        .o_mux         (o_mux),
        .o_sweep_addr  (o_sweep_addr),
        .o_rx          (o_rx),
        .o_rx_valid    (o_rx_valid),
        .o_frame_end   (o_frame_end),
        .o_table_ready (o_table_ready),
        .o_err         (o_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        i_start = 0; i_cal_done = 0; i_sym_valid = 0; i_tb_done = 0; i_sym = '0;
        #1;
        chk("rst_data", {o_mux, o_sweep_addr, o_rx}, 0);
        chk("rst_flags", {o_en_bm, o_rx_valid, o_sym_ready, o_frame_end, o_table_ready, o_err}, 0);
        m_valid = 0; m_end = 0; m_ready = 0; m_tr = 0; m_err = 0; m_rx = '0; m_acc = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic do_sweep(input int cal_at, input int stop_at);
        for (int k = 0; k < stop_at; k++) begin
            @(negedge clk);
            i_start = 0;
`ifdef BM_SEQ_RECAL_EN
            i_recal = 0;
`endif
            i_tb_done = 0;
            i_sym_valid = 0;
            chk("sweep_en", o_en_bm, 1);
            chk("sweep_addr", o_sweep_addr, k);
            chk("sweep_mux", o_mux, {k[9:0], k[5:0] ^ 6'h2A});
            chk("sweep_rdy", o_sym_ready, 0);
            chk("sweep_tr", o_table_ready, 0);
            chk("sweep_err", o_err, m_err);
            i_cal_done = (k == cal_at);
            if ((k == cal_at) != (k == SL - 1)) m_err = 1;
        end
        if (stop_at == SL) begin
            m_tr = 1; m_ready = 1; m_valid = 0; m_end = 0;
        end
    endtask

    task automatic cyc(input logic v, input logic [5:0] s, input logic tb);
        @(negedge clk);
        i_cal_done = 0;
        i_start = 0;
        chk("rx_valid", o_rx_valid, m_valid);
        chk("rx", o_rx, m_rx);
        chk("frame_end", o_frame_end, m_end);
        chk("sym_ready", o_sym_ready, m_ready);
        chk("table_ready", o_table_ready, m_tr);
        chk("err", o_err, m_err);
        chk("run_en", o_en_bm, 1);
        chk("run_mux", o_mux, 16'hFFFF);
        i_sym_valid = v; i_sym = s; i_tb_done = tb;
        m_valid = v && m_ready;
        if (m_valid) begin
            m_rx = s;
            m_acc++;
        end
        m_end = m_valid && (m_acc % FL == 0);
        m_ready = m_end ? 1'b0 : (tb ? 1'b1 : m_ready);
    endtask

    initial begin
        do_reset();
        repeat (3) begin
            @(negedge clk);
            chk("idle_en", o_en_bm, 0);
            chk("idle_mux", o_mux, 0);
            chk("idle_rdy", o_sym_ready, 0);
            i_tb_done = 1;
        end
        @(negedge clk);
        i_tb_done = 0;
        i_start = 1;
        do_sweep(SL - 1, SL);

        for (int i = 1; i <= 4; i++) cyc(1, 6'(i), 0);
        repeat (3) cyc(1, 6'($urandom), 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1'(i % 2 == 0), 6'($urandom), 0);
        cyc(0, 0, 0);
        i_start = 1;
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        for (int i = 0; i < 200; i++) cyc(1'($urandom % 4 != 0), 6'($urandom), 1'($urandom % 6 == 0));
        for (int i = 0; i < 10 && m_ready; i++) cyc(1, 6'($urandom), 0);
        cyc(0, 0, 0);

`ifdef BM_SEQ_RECAL_EN
        cyc(0, 0, 1);
        i_recal = 1;
        do_sweep(SL - 1, SL);
        for (int i = 0; i < 12; i++) cyc(1, 6'($urandom), 0);
`endif

        do_reset();
        @(negedge clk);
        i_start = 1;
        do_sweep(SL - 1, 300);
        do_reset();
        @(negedge clk);
        chk("post_abort_en", o_en_bm, 0);
        i_start = 1;
        do_sweep(500, SL);
        for (int i = 0; i < 40; i++) cyc(1'($urandom % 3 != 0), 6'($urandom), 1'($urandom % 4 == 0));
        @(negedge clk);
        chk("err_sticky", o_err, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bm_sequencer.md
# bm_sequencer

Controller for the branch-metric unit of the Viterbi decoder. It runs the one-time branch-metric table sweep by driving the `{input, state, codeword}` word and `en_bm`. It then admits received 6-bit symbols frame by frame through a valid/ready handshake, forwards them to the branch-metric unit and ACS stage, and holds off the next frame until traceback reports completion.

## Interface
Parameters:
- FRAME_LEN, 64: symbols per frame; legal range 1..65535.
- SWEEP_LEN, 1024: table entries to sweep (`RADIX` × `MAX_STATE_NUM` = 4 × 256).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse that starts the sweep from IDLE.
- i_code  in  6  encoder output codeword for the current `o_sweep_addr`; combinational from the encoder.
- i_cal_done  in  1  `o_cal_done` from the branch-metric unit.
- i_sym  in  6  received sliced symbol.
- i_sym_valid  in  1  upstream symbol valid.
- o_sym_ready  out  1  symbol accepted when high together with `i_sym_valid`.
- i_tb_done  in  1  one-cycle pulse: traceback finished the current frame.
- o_en_bm  out  1  enable to the branch-metric unit.
- o_mux  out  16  bit map: [15:14] input, [13:6] state, [5:0] codeword.
- o_sweep_addr  out  10  sweep index {input, state} presented to the encoder.
- o_rx  out  6  registered symbol to the branch-metric unit.
- o_rx_valid  out  1  `o_rx` is valid this cycle; qualifies the ACS update.
- o_frame_end  out  1  one-cycle pulse with the last symbol of a frame.
- o_table_ready  out  1  table sweep complete.
- o_err  out  1  sticky flag: `i_cal_done` disagreed with the sweep count.

## Operation
- States: IDLE, SWEEP, RUN, WAIT_TB.
- IDLE:
  - `o_en_bm` = 0; all outputs at reset value except the sticky `o_table_ready` and `o_err`.
  - `i_start` → SWEEP with the counter cleared.
- SWEEP:
  - `o_en_bm` = 1.
  - `o_sweep_addr` = counter; `o_mux` = {counter, `i_code`}.
  - The counter increments every cycle. At counter = SWEEP_LEN−1, go to RUN, set `o_table_ready`, and clear the counter.
  - `i_cal_done` must be 1 exactly at counter = 1023. Any mismatch (high earlier, or low at 1023) sets `o_err`.
- RUN:
  - `o_en_bm` = 1; `o_mux` holds `16'hFFFF`.
  - `o_sym_ready` = 1.
  - On a handshake: `o_rx` ← `i_sym`, `o_rx_valid` = 1 the next cycle, symbol counter +1.
  - The handshake that carries symbol FRAME_LEN−1 also produces `o_frame_end` alongside its `o_rx_valid`. The symbol counter then clears and the state goes to WAIT_TB.
  - With no handshake, `o_rx_valid` = 0 and `o_rx` holds its last value.
- WAIT_TB:
  - `o_sym_ready` = 0; `o_en_bm` stays 1 so metric outputs stay stable.
  - `i_tb_done` → RUN.
- Boundary cases:
  - `i_tb_done` outside WAIT_TB is ignored.
  - `i_start` outside IDLE is ignored.
  - `i_sym_valid` without ready is held off; no data loss is the upstream's job.
  - FRAME_LEN = 1: every accepted symbol ends a frame.

## Timing
- Reset (asynchronous, any state, including mid-sweep): state IDLE, counters 0, `o_en_bm` 0, `o_mux` 0, `o_sweep_addr` 0, `o_rx` 0, `o_rx_valid` 0, `o_sym_ready` 0, `o_frame_end` 0, `o_table_ready` 0, `o_err` 0. A sweep interrupted by reset must be restarted by `i_start`.
- Sweep: the first sweep cycle is the cycle after `i_start`. The sweep lasts exactly 1024 cycles, and RUN is entered on cycle 1025.
- Symbol path: fixed 1-cycle latency from handshake to `o_rx`/`o_rx_valid`. Throughput is 1 symbol/cycle in RUN.
- `o_sym_ready` is registered from the state and drops the cycle after the final symbol's handshake.
- WAIT_TB → RUN takes 1 cycle after `i_tb_done`.

## Configuration
- `BM_SEQ_RECAL_EN` defined:
  - Adds input `i_recal` (1 bit).
  - `i_recal` sampled in WAIT_TB or RUN with symbol counter = 0 → re-enter SWEEP; `o_table_ready` clears until the new sweep completes.
  - An `i_recal` that coincides with `i_tb_done` wins.
- Not defined: no port; the table is swept only once per `i_start` from IDLE.

## Structure
- The shared package (`param_def`) holds:
  - The state enum `bm_seq_state_t`.
  - `SLICED_INPUT_NUM`, `MAX_STATE_NUM`, `RADIX`, `MAX_INPUT_NUM`.
  - The sweep length derived as `RADIX*MAX_STATE_NUM`.
- One sub-module is natural: `bm_sweep_cnt`, a 10-bit counter with clear, enable and terminal-count output, which is reusable for the ACS stage's state sweep.
- The symbol counter stays inline.

## Test plan
- Reset, then `i_start` at cycle 5 → `o_en_bm` high cycles 6–1029; `o_sweep_addr` runs 0..1023; `o_table_ready` high from cycle 1030; `o_err` = 0.
- Sweep with the encoder model returning `i_code` = addr[5:0] ^ 6'h2A → `o_mux` = {addr, code} on every sweep cycle.
- FRAME_LEN = 4, `i_sym_valid` held high with symbols 1, 2, 3, 4 → four consecutive `o_rx_valid` pulses with `o_rx` = 1..4; `o_frame_end` with `o_rx` = 4; `o_sym_ready` low until `i_tb_done`, and resumes 1 cycle later.
- Bubbled valid (high every other cycle) → `o_rx_valid` mirrors the gaps; the frame ends on the 4th accepted symbol.
- Branch-metric model raises `i_cal_done` at count 500 → `o_err` set and stays set through the frames that follow.
- Reset asserted at sweep count 300 → all outputs return to reset values immediately; a new `i_start` sweeps the full 1024 cycles. With `BM_SEQ_RECAL_EN`: `i_recal` in WAIT_TB → a 1024-cycle sweep, then RUN.
